// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect4 win checker.
// DRAW_DETECT_EN adds the top-row draw scan states.
package connect4_pkg;

  typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;
  typedef enum logic [1:0] {H = 2'd0, V = 2'd1, D = 2'd2, A = 2'd3} dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FINISH
`ifdef DRAW_DETECT_EN
    ,
    S_DRAW_SCAN,
    S_DRAW_WAIT
`endif
  } state_t;

  localparam int ROWS_DEF    = 6;
  localparam int COLS_DEF    = 7;
  localparam int WIN_LEN_DEF = 4;
  // Width of the signed coordinate arithmetic; wide enough that col-1 at col 0 goes negative.
  localparam int CW          = 4;

  // Per-direction unit step, 2-bit two's complement, indexed by dir_t (H,V,D,A).
  localparam logic [3:0][1:0] DR_TAB = '{2'b01, 2'b01, 2'b01, 2'b00};
  localparam logic [3:0][1:0] DC_TAB = '{2'b11, 2'b01, 2'b00, 2'b01};

  function automatic logic signed [CW-1:0] step_off(input logic [1:0] delta,
                                                    input logic [CW-1:0] k,
                                                    input logic neg);
    logic signed [CW-1:0] off;
    case (delta)
      2'b01:   off = $signed(k);
      2'b11:   off = -$signed(k);
      default: off = '0;
    endcase
    return neg ? -off : off;
  endfunction

endpackage

// File: rtl/connect4_win_checker_stepper.sv
// Walks one scan direction: tracks direction, side, step k and run length,
// and produces the next target cell plus the side/direction end flags.
module win_dir_stepper
  import connect4_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       init_i,
  input  logic       hit_i,
  input  logic       adv_side_i,
  input  logic       next_dir_i,
  input  logic [2:0] drop_row_i,
  input  logic [2:0] drop_col_i,
  output logic [2:0] tgt_row_o,
  output logic [2:0] tgt_col_o,
  output logic       side_end_o,
  output logic       dir_end_o,
  output logic       last_dir_o,
  output logic       run_win_o
);

  localparam logic signed [CW-1:0] ROWS_S = CW'(ROWS);
  localparam logic signed [CW-1:0] COLS_S = CW'(COLS);
  localparam logic [CW-1:0]        K_LIM  = CW'(WIN_LEN);

  dir_t                 dir_q, dir_d;
  logic                 side_q, side_d;
  logic [CW-1:0]        k_q, k_d;
  logic [CW-1:0]        run_q, run_d;
  logic signed [CW-1:0] row_s, col_s;
  logic                 in_bounds;

  always_comb begin
    dir_d  = dir_q;
    side_d = side_q;
    k_d    = k_q;
    run_d  = run_q;
    if (init_i) begin
      dir_d  = H;
      side_d = 1'b0;
      k_d    = CW'(1);
      run_d  = CW'(1);
    end else if (next_dir_i) begin
      dir_d  = dir_t'(dir_q + 2'd1);
      side_d = 1'b0;
      k_d    = CW'(1);
      run_d  = CW'(1);
    end else if (hit_i) begin
      k_d   = k_q + CW'(1);
      run_d = run_q + CW'(1);
    end else if (adv_side_i && !side_q) begin
      side_d = 1'b1;
      k_d    = CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q  <= H;
      side_q <= 1'b0;
      k_q    <= '0;
      run_q  <= '0;
    end else begin
      dir_q  <= dir_d;
      side_q <= side_d;
      k_q    <= k_d;
      run_q  <= run_d;
    end
  end

  assign row_s = $signed({1'b0, drop_row_i}) + step_off(DR_TAB[dir_q], k_q, side_q);
  assign col_s = $signed({1'b0, drop_col_i}) + step_off(DC_TAB[dir_q], k_q, side_q);

  assign in_bounds = !row_s[CW-1] && (row_s < ROWS_S) && !col_s[CW-1] && (col_s < COLS_S);

  assign tgt_row_o  = row_s[2:0];
  assign tgt_col_o  = col_s[2:0];
  assign side_end_o = (k_q >= K_LIM) || !in_bounds;
  // On the minus side, ending the side also completes the direction.
  assign dir_end_o  = side_q;
  assign last_dir_o = (dir_q == A);
  assign run_win_o  = (run_q >= K_LIM);

endmodule

// File: rtl/connect4_win_checker.sv
// Connect4 win checker: scans the board around the landed piece through a 1-cycle read port.
// Define DRAW_DETECT_EN to add the draw output and the top-row draw scan.
module connect4_win_checker
  import connect4_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] drop_row,
  input  logic [2:0] drop_col,
  input  logic [1:0] player,
  output logic       rd_en,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  input  logic [1:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic [1:0] winner,
`ifdef DRAW_DETECT_EN
  output logic       draw,
`endif
  output logic [2:0] dbg_state_o
);

  // Handshake: start is taken only in IDLE (busy=0); every taken start ends in exactly
  // one done pulse unless reset intervenes. rd_data answers the rd_en of the prior cycle.

  state_t     state_q, state_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [1:0] ply_q, ply_d;
  logic       win_q, win_d;
  logic [1:0] winner_q, winner_d;
  logic       st_init, st_hit, st_adv, st_next;
  logic [2:0] tgt_row, tgt_col;
  logic       side_end, dir_end, last_dir, run_win;
  logic       drop_ok;
`ifdef DRAW_DETECT_EN
  logic       draw_q, draw_d, dfull_q, dfull_d;
  logic [2:0] dcol_q, dcol_d;
`endif

  win_dir_stepper #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) u_stepper (
    .clk        (clk),
    .rst_ni     (rst),
    .init_i     (st_init),
    .hit_i      (st_hit),
    .adv_side_i (st_adv),
    .next_dir_i (st_next),
    .drop_row_i (row_q),
    .drop_col_i (col_q),
    .tgt_row_o  (tgt_row),
    .tgt_col_o  (tgt_col),
    .side_end_o (side_end),
    .dir_end_o  (dir_end),
    .last_dir_o (last_dir),
    .run_win_o  (run_win)
  );

  assign drop_ok = (ply_q == P1 || ply_q == P2) &&
                   ({1'b0, row_q} < 4'(ROWS)) && ({1'b0, col_q} < 4'(COLS));

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    ply_d    = ply_q;
    win_d    = win_q;
    winner_d = winner_q;
    st_init  = 1'b0;
    st_hit   = 1'b0;
    st_adv   = 1'b0;
    st_next  = 1'b0;
    rd_en    = 1'b0;
    rd_row   = '0;
    rd_col   = '0;
`ifdef DRAW_DETECT_EN
    draw_d   = draw_q;
    dcol_d   = dcol_q;
    dfull_d  = dfull_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d    = drop_row;
          col_d    = drop_col;
          ply_d    = player;
          win_d    = 1'b0;
          winner_d = 2'b00;
`ifdef DRAW_DETECT_EN
          draw_d   = 1'b0;
`endif
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (drop_ok) begin
          st_init = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_ISSUE: begin
        if (!side_end) begin
          rd_en   = 1'b1;
          rd_row  = tgt_row;
          rd_col  = tgt_col;
          state_d = S_WAIT;
        end else begin
          st_adv  = 1'b1;
          state_d = dir_end ? S_NEXT : S_ISSUE;
        end
      end
      S_WAIT: begin
        if (rd_data == ply_q) begin
          st_hit  = 1'b1;
          state_d = S_ISSUE;
        end else begin
          st_adv  = 1'b1;
          state_d = dir_end ? S_NEXT : S_ISSUE;
        end
      end
      S_NEXT: begin
        if (run_win) begin
          win_d    = 1'b1;
          winner_d = ply_q;
          state_d  = S_FINISH;
        end else if (last_dir) begin
`ifdef DRAW_DETECT_EN
          dcol_d  = '0;
          dfull_d = 1'b1;
          state_d = S_DRAW_SCAN;
`else
          state_d = S_FINISH;
`endif
        end else begin
          st_next = 1'b1;
          state_d = S_ISSUE;
        end
      end
`ifdef DRAW_DETECT_EN
      S_DRAW_SCAN: begin
        rd_en   = 1'b1;
        rd_row  = 3'(ROWS - 1);
        rd_col  = dcol_q;
        state_d = S_DRAW_WAIT;
      end
      S_DRAW_WAIT: begin
        dfull_d = dfull_q && (rd_data != EMPTY);
        if (dcol_q == 3'(COLS - 1)) begin
          draw_d  = dfull_d;
          state_d = S_FINISH;
        end else begin
          dcol_d  = dcol_q + 3'd1;
          state_d = S_DRAW_SCAN;
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      ply_q    <= '0;
      win_q    <= 1'b0;
      winner_q <= 2'b00;
`ifdef DRAW_DETECT_EN
      draw_q   <= 1'b0;
      dcol_q   <= '0;
      dfull_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ply_q    <= ply_d;
      win_q    <= win_d;
      winner_q <= winner_d;
`ifdef DRAW_DETECT_EN
      draw_q   <= draw_d;
      dcol_q   <= dcol_d;
      dfull_q  <= dfull_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done        = (state_q == S_FINISH);
  assign win         = win_q;
  assign winner      = winner_q;
  assign dbg_state_o = state_q;
`ifdef DRAW_DETECT_EN
  assign draw        = draw_q;
`endif

endmodule

// File: tb/tb_connect4_win_checker.sv
// Bench for connect4_win_checker: 6x7 board RAM with 1-cycle read, directed and random drops
// checked against a rule-level model of the expected read sequence and result.
module tb_connect4_win_checker;

`ifdef DRAW_DETECT_EN
  localparam int DRAW_READS = 7;
`else
  localparam int DRAW_READS = 0;
`endif
  localparam int LAT_MAX = 58 + 2 * DRAW_READS;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] drop_row, drop_col;
  logic [1:0] player;
  logic       rd_en;
  logic [2:0] rd_row, rd_col;
  logic [1:0] rd_data = 2'b00;
  logic       busy, done, win;
  logic [1:0] winner;
  logic [2:0] dbg_state;
`ifdef DRAW_DETECT_EN
  logic       draw;
`endif

  connect4_win_checker dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .drop_row   (drop_row),
    .drop_col   (drop_col),
    .player     (player),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .win        (win),
    .winner     (winner),
`ifdef DRAW_DETECT_EN
    .draw       (draw),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- board RAM ----------------
  logic [1:0] board [6][7];

  always @(posedge clk) begin
    if (rd_en) rd_data <= (rd_row < 3'd6 && rd_col < 3'd7) ? board[rd_row][rd_col] : 2'b11;
  end

  // ---------------- request mailbox (driver -> compare) ----------------
  int req_cnt = 0;
  int ack_cnt = 0;
  int req_r, req_c, req_p;
  int pin_reads  = -1;
  int pin_winner = -1;

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad = 0;
  logic [5:0] exp_q[$];
  int         exp_win, exp_winner, exp_draw;
  bit         active = 0;
  int         cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int step_r(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int step_c(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 1;
      default: return -1;
    endcase
  endfunction

  // Expected reads and result straight from the scan rules on the current board.
  task automatic build_model(input int r, input int c, input int p);
    int run, rr, cc, sg;
    exp_q.delete();
    exp_win = 0;
    exp_winner = 0;
    exp_draw = 0;
    if (!(p == 1 || p == 2) || r >= 6 || c >= 7) return;
    for (int d = 0; d < 4 && exp_win == 0; d++) begin
      run = 1;
      for (int s = 0; s < 2; s++) begin
        sg = (s == 0) ? 1 : -1;
        for (int k = 1; k < 4; k++) begin
          rr = r + sg * k * step_r(d);
          cc = c + sg * k * step_c(d);
          if (rr < 0 || rr >= 6 || cc < 0 || cc >= 7) break;
          exp_q.push_back({rr[2:0], cc[2:0]});
          if (board[rr][cc] != p[1:0]) break;
          run++;
        end
      end
      if (run >= 4) begin
        exp_win = 1;
        exp_winner = p;
      end
    end
`ifdef DRAW_DETECT_EN
    if (exp_win == 0) begin
      exp_draw = 1;
      for (int c2 = 0; c2 < 7; c2++) begin
        exp_q.push_back({3'd5, c2[2:0]});
        if (board[5][c2] == 2'b00) exp_draw = 0;
      end
    end
`endif
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_win", win, 0);
      chk("rst_winner", winner, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", {rd_row, rd_col}, 0);
      chk("rst_state", dbg_state, 0);
`ifdef DRAW_DETECT_EN
      chk("rst_draw", draw, 0);
`endif
      exp_q.delete();
      active = 0;
      ack_cnt = req_cnt;
    end else begin
      if (!active && req_cnt != ack_cnt) begin
        build_model(req_r, req_c, req_p);
        if (pin_reads >= 0) chk("model_reads", exp_q.size(), pin_reads);
        if (pin_winner >= 0) chk("model_winner", exp_winner, pin_winner);
        active = 1;
        cyc = 0;
      end
      if (rd_en) begin
        if (!active) chk("stray_read", rd_en, 0);
        else if (exp_q.size() == 0) chk("extra_read", rd_en, 0);
        else chk("read_addr", {rd_row, rd_col}, exp_q.pop_front());
      end
      if (active) begin
        cyc++;
        if (done) begin
          chk("done_busy", busy, 0);
          chk("win", win, exp_win);
          chk("winner", winner, exp_winner);
`ifdef DRAW_DETECT_EN
          chk("draw", draw, exp_draw);
`endif
          chk("reads_missing", exp_q.size(), 0);
          active = 0;
          ack_cnt = req_cnt;
        end else begin
          chk("busy", busy, 1);
          chk("result_cleared", {win, winner}, 0);
          if (cyc >= LAT_MAX) begin
            chk("done_latency", done, 1);
            exp_q.delete();
            active = 0;
            ack_cnt = req_cnt;
          end
        end
      end else begin
        if (done) chk("stray_done", done, 0);
        chk("idle_busy", busy, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_board();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) board[r][c] = 2'b00;
  endtask

  task automatic launch(input int r, input int c, input int p, input int preads, input int pwin);
    @(posedge clk); #1;
    drop_row = r[2:0];
    drop_col = c[2:0];
    player   = p[1:0];
    start    = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    req_r      = r;
    req_c      = c;
    req_p      = p;
    pin_reads  = preads;
    pin_winner = pwin;
    req_cnt++;
  endtask

  task automatic run_drop(input int r, input int c, input int p, input int preads, input int pwin);
    launch(r, c, p, preads, pwin);
    wait (ack_cnt == req_cnt);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v, r, c, p;
    rst = 1'b0;
    start = 1'b0;
    drop_row = '0;
    drop_col = '0;
    player = '0;
    clear_board();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Bottom row H win found on the minus side.
    clear_board();
    for (int i = 0; i < 4; i++) board[0][i] = 2'b10;
    run_drop(0, 3, 2, 4, 2);

    // Vertical win below a piece at row 3.
    clear_board();
    for (int i = 0; i < 3; i++) board[i][4] = 2'b01;
    board[3][4] = 2'b01;
    run_drop(3, 4, 1, 6, 1);

    // Diagonal win from the middle of the run.
    clear_board();
    for (int i = 0; i < 4; i++) board[i][i] = 2'b01;
    run_drop(1, 1, 1, 8, 1);

    // Corner piece on an empty board: bounds trimming, no win.
    clear_board();
    board[0][6] = 2'b10;
    run_drop(0, 6, 2, 3 + DRAW_READS, 0);

    // Gap fill making a run of five.
    clear_board();
    for (int i = 0; i < 5; i++) board[0][i] = 2'b01;
    run_drop(0, 2, 1, 5, 1);

    // Invalid requests: no reads, no win.
    clear_board();
    run_drop(6, 2, 1, 0, 0);
    run_drop(2, 7, 2, 0, 0);
    run_drop(2, 2, 3, 0, 0);
    run_drop(2, 2, 0, 0, 0);

    // A second start mid-scan is ignored.
    clear_board();
    board[2][3] = 2'b01;
    launch(2, 3, 1, 8 + DRAW_READS, 0);
    repeat (5) @(posedge clk);
    #1;
    drop_row = 3'd0;
    drop_col = 3'd0;
    player   = 2'b10;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait (ack_cnt == req_cnt);
    @(posedge clk); #1;

    // Reset mid-scan aborts with no done pulse.
    launch(2, 3, 1, -1, -1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

`ifdef DRAW_DETECT_EN
    // Full top row without a win reports a draw.
    clear_board();
    board[5][0] = 2'b01; board[5][1] = 2'b01; board[5][2] = 2'b10; board[5][3] = 2'b10;
    board[5][4] = 2'b01; board[5][5] = 2'b01; board[5][6] = 2'b10;
    run_drop(5, 2, 2, 13, 0);
`endif

    // Random boards and drops.
    for (int t = 0; t < 150; t++) begin
      for (int rr = 0; rr < 6; rr++)
        for (int cc = 0; cc < 7; cc++) begin
          v = $urandom_range(0, 9);
          board[rr][cc] = (v < 4) ? 2'b00 : (v < 7) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
        end
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 7);
        c = $urandom_range(0, 7);
        p = $urandom_range(0, 3);
      end else begin
        r = $urandom_range(0, 5);
        c = $urandom_range(0, 6);
        p = $urandom_range(1, 2);
      end
      if (r < 6 && c < 7) board[r][c] = p[1:0];
      run_drop(r, c, p, -1, -1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
